// File: rtl/data_types_pkg.sv
// Shared core data types and dmem responder defaults used by RTL and benches.
package data_types;

  typedef logic [31:0] word32_t;

  localparam int unsigned DMEM_LATENCY_DEFAULT = 2;
  localparam int unsigned DMEM_DEPTH_DEFAULT   = 1024;

endpackage

// File: rtl/dmem_responder_sram_array.sv
// Single-port word array: synchronous write, synchronous registered read (read-before-write).
module dmem_sram_array
  import data_types::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W      = $clog2(DMEM_DEPTH_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word32_t           wdata,
  output word32_t           rdata
);

  word32_t mem [DEPTH_WORDS];

  // Storage is never reset so committed writes survive a core reset.
  always_ff @(posedge clk_i) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Output register captures the pre-write word, so a write returns the old value.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the dmem protocol: fixed-latency done pulse, sticky error flag.
module dmem_responder
  import data_types::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter int unsigned LATENCY     = DMEM_LATENCY_DEFAULT
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    dmem_read_i,
  input  logic    dmem_write_i,
  input  word32_t dmem_addr_i,
  input  word32_t dmem_data_i,
  output word32_t dmem_rd_data_o,
  output logic    dmem_done_o,
  output logic    err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (LATENCY == 0) begin : g_lat_chk
    $error("dmem_responder: LATENCY must be >= 1");
  end
  if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_depth_chk
    $error("dmem_responder: DEPTH_WORDS must be a power of 2 and >= 2");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          oor_q, oor_d;
  logic          done_q, done_d;
  logic          rd_req, wr_req, both_req, any_req;
  logic          addr_oor, accept, sram_en;
  logic [AW-1:0] word_idx;
  word32_t       sram_rdata;

  assign rd_req   = dmem_read_i & ~dmem_write_i;
  assign wr_req   = dmem_write_i & ~dmem_read_i;
  assign both_req = dmem_read_i & dmem_write_i;
  assign any_req  = dmem_read_i | dmem_write_i;
  assign addr_oor = (dmem_addr_i >> (AW + 2)) != '0;
  assign word_idx = dmem_addr_i[2 +: AW];
  assign accept   = (state_q == IDLE) & (rd_req | wr_req);
  assign sram_en  = accept & ~addr_oor;

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_array (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en     (sram_en),
    .we     (wr_req),
    .addr   (word_idx),
    .wdata  (dmem_data_i),
    .rdata  (sram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (both_req) begin
          err_d = 1'b1;
        end else if (rd_req || wr_req) begin
          oor_d = addr_oor;
          if (addr_oor) begin
            err_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (any_req) begin
          err_d = 1'b1;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (any_req) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  // Out-of-range accesses never touch the array and report zero data.
  assign dmem_rd_data_o = oor_q ? '0 : sram_rdata;
  assign dmem_done_o    = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=2 and LATENCY=1.
module tb_dmem_responder;
  import data_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata1, rdata2;
  logic        done1, done2, err1, err2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DMEM_DEPTH_DEFAULT), .LATENCY(2)) dut2 (
    .clk_i(clk), .reset_i(rst_n), .dmem_read_i(rd), .dmem_write_i(wr),
    .dmem_addr_i(addr), .dmem_data_i(wdata), .dmem_rd_data_o(rdata2),
    .dmem_done_o(done2), .err_o(err2)
  );

  dmem_responder #(.DEPTH_WORDS(DMEM_DEPTH_DEFAULT), .LATENCY(1)) dut1 (
    .clk_i(clk), .reset_i(rst_n), .dmem_read_i(rd), .dmem_write_i(wr),
    .dmem_addr_i(addr), .dmem_data_i(wdata), .dmem_rd_data_o(rdata1),
    .dmem_done_o(done1), .err_o(err1)
  );

  function automatic logic sel_done(input int lat);
    return (lat == 1) ? done1 : done2;
  endfunction

  function automatic logic [31:0] sel_rdata(input int lat);
    return (lat == 1) ? rdata1 : rdata2;
  endfunction

  function automatic logic sel_err(input int lat);
    return (lat == 1) ? err1 : err2;
  endfunction

  // Drive a request for 'hold' cycles, then watch 'window' cycles for done pulses.
  task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input int hold,
                         input int window, output int cnt, output int first,
                         output logic [31:0] dat);
    cnt = 0;
    first = -1;
    dat = 32'hxxxx_xxxx;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (k == hold) begin
        rd = 1'b0; wr = 1'b0;
      end
      if (sel_done(lat) === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = k;
          dat = sel_rdata(lat);
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL reset_done2 got=%b exp=0", done2); end
    checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err2 got=%b exp=0", err2); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done1 got=%b exp=0", done1); end
    checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL reset_err1 got=%b exp=0", err1); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read(input int lat, input logic [31:0] val);
    int cnt, first;
    logic [31:0] dat;
    run_req(1'b0, 1'b1, 32'h10, val, lat, 1, lat + 2, cnt, first, dat);
    checks++; if (cnt !== 1) begin failures++; $display("FAIL wr_done_count lat=%0d got=%0d exp=1", lat, cnt); end
    checks++; if (first !== lat) begin failures++; $display("FAIL wr_done_cycle lat=%0d got=%0d exp=%0d", lat, first, lat); end
    run_req(1'b1, 1'b0, 32'h10, 32'h0, lat, 1, lat + 2, cnt, first, dat);
    checks++; if (cnt !== 1) begin failures++; $display("FAIL rd_done_count lat=%0d got=%0d exp=1", lat, cnt); end
    checks++; if (first !== lat) begin failures++; $display("FAIL rd_done_cycle lat=%0d got=%0d exp=%0d", lat, first, lat); end
    checks++; if (dat !== val) begin failures++; $display("FAIL rd_data lat=%0d got=%h exp=%h", lat, dat, val); end
    checks++; if (sel_err(lat) !== 1'b0) begin failures++; $display("FAIL wr_rd_err lat=%0d got=%b exp=0", lat, sel_err(lat)); end
  endtask

  task automatic test_unaligned(input int lat, input logic [31:0] val);
    int cnt, first;
    logic [31:0] dat;
    run_req(1'b1, 1'b0, 32'h13, 32'h0, lat, 1, lat + 2, cnt, first, dat);
    checks++; if (first !== lat) begin failures++; $display("FAIL unaligned_cycle lat=%0d got=%0d exp=%0d", lat, first, lat); end
    checks++; if (dat !== val) begin failures++; $display("FAIL unaligned_data lat=%0d got=%h exp=%h", lat, dat, val); end
  endtask

  task automatic test_busy_request(input int lat, input logic [31:0] val);
    int cnt, first;
    logic [31:0] dat;
    run_req(1'b1, 1'b0, 32'h10, 32'h0, lat, 2, lat + 4, cnt, first, dat);
    checks++; if (cnt !== 1) begin failures++; $display("FAIL busy_done_count lat=%0d got=%0d exp=1", lat, cnt); end
    checks++; if (first !== lat) begin failures++; $display("FAIL busy_done_cycle lat=%0d got=%0d exp=%0d", lat, first, lat); end
    checks++; if (dat !== val) begin failures++; $display("FAIL busy_data lat=%0d got=%h exp=%h", lat, dat, val); end
    checks++; if (sel_err(lat) !== 1'b1) begin failures++; $display("FAIL busy_err lat=%0d got=%b exp=1", lat, sel_err(lat)); end
  endtask

  task automatic test_both_high();
    int cnt, first;
    logic [31:0] dat;
    run_req(1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 2, 1, 5, cnt, first, dat);
    checks++; if (cnt !== 0) begin failures++; $display("FAIL both_done_count got=%0d exp=0", cnt); end
    checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL both_err got=%b exp=1", err2); end
    run_req(1'b1, 1'b0, 32'h10, 32'h0, 2, 1, 4, cnt, first, dat);
    checks++; if (dat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL both_array got=%h exp=deadbeef", dat); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    @(negedge clk);
    wr = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done2); end
    checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%h exp=0", rdata2); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", err2); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done2 === 1'b1) cnt++;
    end
    checks++; if (cnt !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", cnt); end
    begin
      int c2, f2;
      logic [31:0] d2;
      run_req(1'b1, 1'b0, 32'h20, 32'h0, 2, 1, 4, c2, f2, d2);
      checks++; if (d2 !== 32'hCAFE_F00D) begin failures++; $display("FAIL rstmid_committed got=%h exp=cafef00d", d2); end
    end
  endtask

  task automatic test_out_of_range();
    int cnt, first;
    logic [31:0] dat;
    run_req(1'b0, 1'b1, 32'h0, 32'h1111_2222, 2, 1, 4, cnt, first, dat);
    run_req(1'b0, 1'b1, 32'h0, 32'h3333_4444, 2, 1, 4, cnt, first, dat);
    checks++; if (dat !== 32'h1111_2222) begin failures++; $display("FAIL wr_old_value got=%h exp=11112222", dat); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL pre_oor_err got=%b exp=0", err2); end
    run_req(1'b1, 1'b0, DMEM_DEPTH_DEFAULT * 4, 32'h0, 2, 1, 4, cnt, first, dat);
    checks++; if (first !== 2) begin failures++; $display("FAIL oor_done_cycle got=%0d exp=2", first); end
    checks++; if (dat !== 32'h0) begin failures++; $display("FAIL oor_data got=%h exp=0", dat); end
    checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", err2); end
    run_req(1'b0, 1'b1, DMEM_DEPTH_DEFAULT * 4, 32'h5555_6666, 2, 1, 4, cnt, first, dat);
    checks++; if (cnt !== 1) begin failures++; $display("FAIL oor_wr_done got=%0d exp=1", cnt); end
    run_req(1'b1, 1'b0, 32'h0, 32'h0, 2, 1, 4, cnt, first, dat);
    checks++; if (dat !== 32'h3333_4444) begin failures++; $display("FAIL oor_wr_dropped got=%h exp=33334444", dat); end
  endtask

  initial begin
    test_reset();
    test_write_read(2, 32'hDEAD_BEEF);
    test_unaligned(2, 32'hDEAD_BEEF);
    test_busy_request(2, 32'hDEAD_BEEF);
    test_both_high();
    test_reset_mid();
    test_out_of_range();
    pulse_reset();
    test_write_read(1, 32'h1357_9BDF);
    test_unaligned(1, 32'h1357_9BDF);
    test_busy_request(1, 32'h1357_9BDF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
